// File: rtl/conv33_window_gen.sv
// conv33_window_gen: 3x3 sliding-window builder (two line buffers + shift array); `CONV33_WIN_STRIDE2_EN selects stride-2 emission.
// Window valid one cycle after its last pixel is accepted; pix_ready drops only while a held window is not being taken.
module conv33_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [DATA_WIDTH-1:0] win_0_0,
  output logic [DATA_WIDTH-1:0] win_0_1,
  output logic [DATA_WIDTH-1:0] win_0_2,
  output logic [DATA_WIDTH-1:0] win_1_0,
  output logic [DATA_WIDTH-1:0] win_1_1,
  output logic [DATA_WIDTH-1:0] win_1_2,
  output logic [DATA_WIDTH-1:0] win_2_0,
  output logic [DATA_WIDTH-1:0] win_2_1,
  output logic [DATA_WIDTH-1:0] win_2_2,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] sh_q  [3][3];
  logic [DATA_WIDTH-1:0] sh_d  [3][3];
  logic [DATA_WIDTH-1:0] win_q [3][3];
  logic [DATA_WIDTH-1:0] win_d [3][3];
  logic                  win_valid_q, win_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] lb0_q [IMG_W];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_W];
  logic                  accept, emit, col_last, row_last;

  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);

`ifdef CONV33_WIN_STRIDE2_EN
  assign emit = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO) && !row_q[0] && !col_q[0];
`else
  assign emit = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    sh_d  = sh_q;
    if (accept) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        row_d = row_last ? '0 : row_q + 1'b1;
      end
      for (int r = 0; r < 3; r++) begin
        sh_d[r][0] = sh_q[r][1];
        sh_d[r][1] = sh_q[r][2];
      end
      // New right-hand column: two rows back, one row back, current pixel.
      sh_d[0][2] = lb0_q[col_q];
      sh_d[1][2] = lb1_q[col_q];
      sh_d[2][2] = pix_in;
    end
  end

  always_comb begin
    win_d        = win_q;
    win_valid_d  = win_valid_q && !win_ready;
    frame_done_d = accept && row_last && col_last;
    if (emit) begin
      win_d       = sh_d;
      win_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      sh_q         <= '{default: '0};
      win_q        <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers hold no state that matters across reset; row gating hides stale rows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix_in;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign win_0_0    = win_q[0][0];
  assign win_0_1    = win_q[0][1];
  assign win_0_2    = win_q[0][2];
  assign win_1_0    = win_q[1][0];
  assign win_1_1    = win_q[1][1];
  assign win_1_2    = win_q[1][2];
  assign win_2_0    = win_q[2][0];
  assign win_2_1    = win_q[2][1];
  assign win_2_2    = win_q[2][2];

endmodule

// File: doc/conv33_window_gen.md
# conv33_window_gen

Sliding-window generator directly upstream of the 3x3 convolution input stage. Accepts a raster-order pixel stream and builds 3x3 windows using two line buffers and a 3x3 shift array. Presents each complete window on a one-deep valid/ready output register that drives the convolution stage's `input_valid`, `in_r_c` and `input_ready` ports. Only "valid" convolution positions are emitted; there is no padding.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits.
- `IMG_W`, 28, frame width in pixels; must be ≥ 3.
- `IMG_H`, 28, frame height in pixels; must be ≥ 3.
- `clk` input 1 — the single clock; all logic is on its rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `pix_valid` input 1 — `pix_in` is valid.
- `pix_ready` output 1 — block can accept a pixel.
- `pix_in` input DATA_WIDTH — pixel, raster order, row 0 column 0 first.
- `win_valid` output 1 — window outputs hold a complete window; connects to the conv stage's `input_valid`.
- `win_ready` input 1 — downstream accepts the window; connects from the conv stage's `input_ready`.
- `win_0_0` … `win_2_2` output DATA_WIDTH each, nine ports. `win_r_c` is window row r (0 = top, oldest) and column c (0 = left, oldest).
- `frame_done` output 1 — one-cycle pulse marking the window produced by the last pixel of a frame.

## Operation
- A pixel is accepted when `pix_valid && pix_ready`. Nothing changes on cycles without an accept, except the output handshake.
- `pix_ready = !win_valid || win_ready`. This is combinational, so there is no bubble at full throughput.
- Position counters:
  - `col` runs 0..IMG_W-1, width `$clog2(IMG_W)`.
  - `row` runs 0..IMG_H-1, width `$clog2(IMG_H)`.
  - Both advance only on an accept.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1) both wrap to 0, and the next frame follows back-to-back.
- Line buffers `lb0` (two rows back) and `lb1` (one row back), each IMG_W deep. On an accept at column c: `lb0[c] <= lb1[c]` and `lb1[c] <= pix_in`.
- Shift array: on every accept, columns shift left (column 0 is discarded). The new column 2 is {`lb0[c]`, `lb1[c]`, `pix_in`} for rows {0, 1, 2}.
- Window emit condition, evaluated on the accepted pixel: `row >= 2 && col >= 2`. Windows never straddle a row boundary because of `col >= 2`.
- Emitting loads the nine `win_*` outputs from the updated shift array and sets `win_valid`.
- Handshake:
  - `win_valid` falls when `win_ready` is high and no new window is emitted in the same cycle.
  - Outputs are stable while `win_valid && !win_ready`.
- `frame_done` is set on the cycle after the accept of pixel (IMG_H-1, IMG_W-1), coincident with the last window's `win_valid`. It stays high for exactly one cycle.
- Windows per frame: (IMG_W-2)*(IMG_H-2), which is 676 at defaults.
- Line-buffer contents are not cleared between frames. Stale data is never emitted because of the `row >= 2` gating.

## Timing
- Reset state:
  - `win_valid = 0`, `frame_done = 0`, all `win_*` = 0.
  - `row = col = 0`, shift array = 0.
  - `pix_ready = 1`.
  - Line buffers are not reset.
- Latency: pixel accepted at cycle N gives `win_valid` high at N+1.
- Throughput: one pixel per cycle while `win_ready` is held high.
- Stall: with `win_valid = 1` and `win_ready = 0`, `pix_ready = 0` and all state is frozen.
- Simultaneous `win_ready` and a new emit: the output register reloads and `win_valid` stays 1.
- Reset asserted mid-frame: everything returns to the reset state immediately. A partial window is never emitted afterwards, and the next accepted pixel is treated as row 0, column 0.

## Configuration
- `CONV33_WIN_STRIDE2_EN`
  - Defined: the emit condition additionally requires `row[0] == 0 && col[0] == 0`, giving stride-2 windows. The window count is floor((IMG_W-1)/2)*floor((IMG_H-1)/2), which is 169 at defaults. `frame_done` then pulses on the cycle after the last pixel of the frame is accepted, whether or not that pixel emits a window.
  - Undefined: stride 1, as described above.

## Test plan
All scenarios use IMG_W=5, IMG_H=4, with pixel value = row*5 + col.
- Reset with `rst` low, then release: all outputs are 0 and `pix_ready = 1`.
- Stream 20 pixels with `win_ready` held at 1: exactly 6 windows, each one cycle after the accept of pixels 12, 13, 14, 17, 18, 19.
  - The first window, row-major 0_0..2_2, is 0,1,2,5,6,7,10,11,12.
  - The last window is 7,8,9,12,13,14,17,18,19.
  - `frame_done` is high only alongside the last window.
- Hold `win_ready` at 0 for 4 cycles after the first window: the window stays held at 0,1,2,5,6,7,10,11,12 and `pix_ready = 0`. After release, the remaining 5 windows are bit-exact with no loss or duplication.
- Pull `rst` low after pixel 8, then send a full frame: only 6 windows, identical to the clean run.
- Two back-to-back frames: 12 windows in total and two `frame_done` pulses. The second frame's first window is 0,1,2,5,6,7,10,11,12.
- With `CONV33_WIN_STRIDE2_EN` defined, stream 20 pixels: exactly 2 windows, from pixels 12 and 14, with values 0,1,2,5,6,7,10,11,12 and 2,3,4,7,8,9,12,13,14.
